// File: rtl/front_pipe_regs.sv
// Front-end pipeline registers for the 5-stage MIPS core: PC, IF/ID and ID/EX,
// with hazard-unit stall/flush handling and saturating stall/flush event counters.
module front_pipe_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Stall,
  input  logic             PCWrite,
  input  logic             IF_ID_Write,
  input  logic             Flush,
  input  logic [31:0]      BranchTarget,
  input  logic [31:0]      IMem_Instr,
  input  logic [8:0]       ID_Ctrl,
  output logic [31:0]      PC,
  output logic [31:0]      IF_ID_Instr,
  output logic [31:0]      IF_ID_PC4,
  output logic [4:0]       IF_ID_RegisterRs,
  output logic [4:0]       IF_ID_RegisterRt,
  output logic [8:0]       ID_EX_Ctrl,
  output logic             ID_EX_MemRead,
  output logic [4:0]       ID_EX_RegisterRs,
  output logic [4:0]       ID_EX_RegisterRt,
  output logic [4:0]       ID_EX_RegisterRd,
  output logic [31:0]      ID_EX_PC4,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CTRL_W   = 9;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned MEMRD_IX = 6;

  logic [XLEN-1:0]  pcPlus4;
  logic [CNT_W-1:0] cntMax;
  logic             bubble;

  assign pcPlus4 = PC + XLEN'(4);
  assign cntMax  = {CNT_W{1'b1}};
  assign bubble  = Flush | Stall;

  // Register-field taps feeding the hazard unit; no input reaches them combinationally.
  assign IF_ID_RegisterRs = IF_ID_Instr[25:21];
  assign IF_ID_RegisterRt = IF_ID_Instr[20:16];
  assign ID_EX_MemRead    = ID_EX_Ctrl[MEMRD_IX];

  // Fetch address: a taken branch overrides any PC hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC <= RESET_PC;
    end else if (Flush) begin
      PC <= BranchTarget;
    end else if (PCWrite) begin
      PC <= pcPlus4;
    end
  end

  // IF/ID: cleared to a NOP on flush, held while the hazard unit stalls decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_Instr <= '0;
      IF_ID_PC4   <= '0;
    end else if (Flush) begin
      IF_ID_Instr <= '0;
      IF_ID_PC4   <= '0;
    end else if (IF_ID_Write) begin
      IF_ID_Instr <= IMem_Instr;
      IF_ID_PC4   <= pcPlus4;
    end
  end

  // ID/EX: a bubble zeroes MemRead too, so a load-use stall ends after one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_Ctrl       <= '0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
      ID_EX_PC4        <= '0;
    end else if (bubble) begin
      ID_EX_Ctrl       <= '0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
      ID_EX_PC4        <= '0;
    end else begin
      ID_EX_Ctrl       <= CTRL_W'(ID_Ctrl);
      ID_EX_RegisterRs <= REG_W'(IF_ID_Instr[25:21]);
      ID_EX_RegisterRt <= REG_W'(IF_ID_Instr[20:16]);
      ID_EX_RegisterRd <= REG_W'(IF_ID_Instr[15:11]);
      ID_EX_PC4        <= IF_ID_PC4;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (Stall && (StallCount != cntMax)) StallCount <= StallCount + CNT_W'(1);
      if (Flush && (FlushCount != cntMax)) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_front_pipe_regs.sv
// Directed bench for front_pipe_regs: vector table plus reset, load-use and
// counter-saturation sequences.
module tb_front_pipe_regs;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             Stall, PCWrite, IF_ID_Write, Flush;
  logic [31:0]      BranchTarget, IMem_Instr;
  logic [8:0]       ID_Ctrl;
  logic [31:0]      PC, IF_ID_Instr, IF_ID_PC4, ID_EX_PC4;
  logic [4:0]       IF_ID_RegisterRs, IF_ID_RegisterRt;
  logic [8:0]       ID_EX_Ctrl;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegisterRd;
  logic [CNT_W-1:0] StallCount, FlushCount;

  // Directed inputs, or the hazard-unit / imem / decode model when hzEn is set.
  logic        hzEn;
  logic        stallV, pcwV, ifwV, flushV;
  logic [31:0] targetV, instrV;
  logic [8:0]  ctrlV;
  logic        hzStall;
  logic [8:0]  decCtrl;
  logic [31:0] imem [4];

  int tests = 0;
  int fails = 0;

  front_pipe_regs #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write), .Flush(Flush), .BranchTarget(BranchTarget),
    .IMem_Instr(IMem_Instr), .ID_Ctrl(ID_Ctrl), .PC(PC),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .ID_EX_Ctrl(ID_EX_Ctrl), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_RegisterRs(ID_EX_RegisterRs), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .ID_EX_RegisterRd(ID_EX_RegisterRd), .ID_EX_PC4(ID_EX_PC4),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    hzStall = ID_EX_MemRead &&
              ((ID_EX_RegisterRt == IF_ID_RegisterRs) || (ID_EX_RegisterRt == IF_ID_RegisterRt));
    if (IF_ID_Instr == 32'h0)              decCtrl = 9'h000;
    else if (IF_ID_Instr[31:26] == 6'h23)  decCtrl = 9'h1C8;
    else                                   decCtrl = 9'h106;
    Stall        = hzEn ? hzStall  : stallV;
    PCWrite      = hzEn ? !hzStall : pcwV;
    IF_ID_Write  = hzEn ? !hzStall : ifwV;
    Flush        = hzEn ? 1'b0     : flushV;
    BranchTarget = targetV;
    IMem_Instr   = hzEn ? imem[PC[3:2]] : instrV;
    ID_Ctrl      = hzEn ? decCtrl  : ctrlV;
  end

  typedef struct {
    logic        flush, stall, pcw, ifw;
    logic [31:0] target, instr;
    logic [8:0]  ctrl;
    logic [31:0] ePc, eIfInstr, eIfPc4;
    logic [8:0]  eCtrl;
    logic [4:0]  eRs, eRt, eRd;
    logic [31:0] eIdPc4;
    logic [3:0]  eStallCnt, eFlushCnt;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic f, input logic s, input logic pw, input logic iw,
                       input logic [31:0] t, input logic [31:0] ins, input logic [8:0] c);
    flushV = f; stallV = s; pcwV = pw; ifwV = iw; targetV = t; instrV = ins; ctrlV = c;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    hzEn = 1'b0;
    rst_n = 1'b0;
    setIn(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0022_1820, 9'h106);
    imem[0] = 32'h8C22_0000;  // lw  $2,0($1)
    imem[1] = 32'h0044_1820;  // add $3,$2,$4
    imem[2] = 32'h0;
    imem[3] = 32'h0;

    //             f  s  pw iw target        instr         ctrl    ePc           eIfInstr      eIfPc4        eCtrl  rs rt rd eIdPc4  sc fc
    vecs[0]  = '{0, 0, 1, 1, 32'h0,        32'h0022_1820, 9'h1A3, 32'h4,        32'h0022_1820, 32'h4,       9'h1A3, 0, 0, 0, 32'h0,  0, 0};
    vecs[1]  = '{0, 0, 1, 1, 32'h0,        32'h0085_3020, 9'h0F0, 32'h8,        32'h0085_3020, 32'h8,       9'h0F0, 1, 2, 3, 32'h4,  0, 0};
    vecs[2]  = '{0, 1, 0, 0, 32'h0,        32'h0109_5020, 9'h155, 32'h8,        32'h0085_3020, 32'h8,       9'h000, 0, 0, 0, 32'h0,  1, 0};
    vecs[3]  = '{0, 0, 1, 1, 32'h0,        32'h0109_5020, 9'h155, 32'hC,        32'h0109_5020, 32'hC,       9'h155, 4, 5, 6, 32'h8,  1, 0};
    vecs[4]  = '{0, 0, 0, 1, 32'h0,        32'h014B_6020, 9'h001, 32'hC,        32'h014B_6020, 32'h10,      9'h001, 8, 9, 10, 32'hC, 1, 0};
    vecs[5]  = '{0, 0, 1, 0, 32'h0,        32'h018D_7020, 9'h002, 32'h10,       32'h014B_6020, 32'h10,      9'h002, 10, 11, 12, 32'h10, 1, 0};
    vecs[6]  = '{1, 0, 1, 1, 32'h100,      32'h018D_7020, 9'h1FF, 32'h100,      32'h0,         32'h0,       9'h000, 0, 0, 0, 32'h0,  1, 1};
    vecs[7]  = '{1, 1, 0, 0, 32'h200,      32'h018D_7020, 9'h1FF, 32'h200,      32'h0,         32'h0,       9'h000, 0, 0, 0, 32'h0,  2, 2};
    vecs[8]  = '{1, 0, 0, 0, 32'hFFFF_FFFC, 32'h018D_7020, 9'h1FF, 32'hFFFF_FFFC, 32'h0,        32'h0,       9'h000, 0, 0, 0, 32'h0,  2, 3};
    vecs[9]  = '{0, 0, 1, 1, 32'h0,        32'h0022_1820, 9'h0AA, 32'h0,        32'h0022_1820, 32'h0,       9'h0AA, 0, 0, 0, 32'h0,  2, 3};
    vecs[10] = '{0, 0, 1, 1, 32'h0,        32'h0085_3020, 9'h111, 32'h4,        32'h0085_3020, 32'h4,       9'h111, 1, 2, 3, 32'h0,  2, 3};

    // Reset and run, then asynchronous reset from PC=0x40.
    #3;
    rst_n = 1'b1;
    repeat (16) step();
    check("run_pc_0x40", PC, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", PC, 32'h0);
    check("async_rst_ifid", IF_ID_Instr, 32'h0);
    check("async_rst_ifpc4", IF_ID_PC4, 32'h0);
    check("async_rst_ctrl", 32'(ID_EX_Ctrl), 32'h0);
    check("async_rst_rd", 32'(ID_EX_RegisterRd), 32'h0);
    check("async_rst_idpc4", ID_EX_PC4, 32'h0);
    rst_n = 1'b1;
    repeat (3) step();
    check("run3_pc", PC, 32'hC);
    check("run3_ifpc4", IF_ID_PC4, 32'hC);

    // Vector table from a fresh reset.
    doReset();
    for (int i = 0; i < 11; i++) begin
      setIn(vecs[i].flush, vecs[i].stall, vecs[i].pcw, vecs[i].ifw,
            vecs[i].target, vecs[i].instr, vecs[i].ctrl);
      step();
      check($sformatf("v%0d_pc", i), PC, vecs[i].ePc);
      check($sformatf("v%0d_ifinstr", i), IF_ID_Instr, vecs[i].eIfInstr);
      check($sformatf("v%0d_ifpc4", i), IF_ID_PC4, vecs[i].eIfPc4);
      check($sformatf("v%0d_ifrs", i), 32'(IF_ID_RegisterRs), 32'(vecs[i].eIfInstr[25:21]));
      check($sformatf("v%0d_ifrt", i), 32'(IF_ID_RegisterRt), 32'(vecs[i].eIfInstr[20:16]));
      check($sformatf("v%0d_ctrl", i), 32'(ID_EX_Ctrl), 32'(vecs[i].eCtrl));
      check($sformatf("v%0d_memrd", i), 32'(ID_EX_MemRead), 32'(vecs[i].eCtrl[6]));
      check($sformatf("v%0d_rs", i), 32'(ID_EX_RegisterRs), 32'(vecs[i].eRs));
      check($sformatf("v%0d_rt", i), 32'(ID_EX_RegisterRt), 32'(vecs[i].eRt));
      check($sformatf("v%0d_rd", i), 32'(ID_EX_RegisterRd), 32'(vecs[i].eRd));
      check($sformatf("v%0d_idpc4", i), ID_EX_PC4, vecs[i].eIdPc4);
      check($sformatf("v%0d_stallcnt", i), 32'(StallCount), 32'(vecs[i].eStallCnt));
      check($sformatf("v%0d_flushcnt", i), 32'(FlushCount), 32'(vecs[i].eFlushCnt));
    end

    // Load-use with the hazard-unit model in the loop.
    doReset();
    hzEn = 1'b1;
    step();
    check("lu1_ifinstr", IF_ID_Instr, 32'h8C22_0000);
    step();
    check("lu2_ctrl_lw", 32'(ID_EX_Ctrl), 32'h1C8);
    check("lu2_pc", PC, 32'h8);
    step();
    check("lu3_bubble", 32'(ID_EX_Ctrl), 32'h0);
    check("lu3_pc_held", PC, 32'h8);
    check("lu3_if_held", IF_ID_Instr, 32'h0044_1820);
    check("lu3_stallcnt", 32'(StallCount), 32'h1);
    step();
    check("lu4_ctrl_add", 32'(ID_EX_Ctrl), 32'h106);
    check("lu4_rs", 32'(ID_EX_RegisterRs), 32'h2);
    check("lu4_rd", 32'(ID_EX_RegisterRd), 32'h3);
    check("lu4_pc", PC, 32'hC);
    check("lu4_stallcnt", 32'(StallCount), 32'h1);
    hzEn = 1'b0;

    // Counter saturation at CNT_W=4.
    doReset();
    setIn(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 9'h0);
    repeat (14) step();
    check("sat_stall14", 32'(StallCount), 32'd14);
    check("sat_flush0", 32'(FlushCount), 32'd0);
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 9'h0);
    repeat (6) step();
    check("sat_stall15", 32'(StallCount), 32'd15);
    check("sat_flush6", 32'(FlushCount), 32'd6);
    check("sat_pc_target", PC, 32'h300);
    setIn(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 9'h0);
    repeat (12) step();
    check("sat_flush15", 32'(FlushCount), 32'd15);
    check("sat_stall_hold", 32'(StallCount), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
